// File: rtl/eight_bit_serializer_pkg.sv
// serializer_pkg: shared state encoding and framing constants for the
// eight_bit_serializer transmit path.
package serializer_pkg;

   // Frame phases; PARITY is only reachable when PARITY_EN is defined
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_e;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;
   localparam int   DATA_BITS = 8;

endpackage

// File: rtl/eight_bit_serializer_if.sv
// eight_bit_serializer_if: byte load handshake plus serial line and status.
// master = byte producer, slave = serializer.
interface eight_bit_serializer_if;
   logic [7:0] d_in;
   logic       load;
   logic       ready;
   logic       busy;
   logic       ser_out;
   logic       done;

   modport master (output d_in, load, input ready, busy, ser_out, done);
   modport slave  (input d_in, load, output ready, busy, ser_out, done);
endinterface

// File: rtl/eight_bit_serializer_bit_timer.sv
// bit_timer: counts 0..BIT_CYCLES-1 clocks of one serial bit; tick marks the
// last clock. restart forces the count back to 0 for the next clock.
module bit_timer #(
   parameter int unsigned BIT_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);
   localparam logic [7:0] LAST = 8'(BIT_CYCLES - 1);

   logic [7:0] cnt_q, cnt_d;

   assign tick = (cnt_q == LAST);

   // next count: reload on restart, otherwise advance
   always_comb begin
      cnt_d = cnt_q + 8'd1;
      if (restart) cnt_d = 8'd0;
   end

   // count register
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= 8'd0;
      else     cnt_q <= cnt_d;
   end
endmodule

// File: rtl/eight_bit_serializer.sv
// eight_bit_serializer: parallel-in serial-out byte transmitter. Frame is a
// start bit (0), d_in[0..7] LSB first, optional even parity, stop bit (1),
// each held BIT_CYCLES clocks. Macro PARITY_EN inserts the parity bit.
// Outputs are registered from the current state, so the line lags the FSM by
// one clock: load sampled at edge N gives ser_out=0 from edge N+1.
module eight_bit_serializer
   import serializer_pkg::*;
#(
   parameter int unsigned BIT_CYCLES = 4
) (
   input logic                   clk,
   input logic                   rst,
   eight_bit_serializer_if.slave bus
);
   state_e     state_q, state_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] idx_q, idx_d;
   logic       ser_out_q, ser_out_d;
   logic       done_q, done_d;
   logic       ready_q, ready_d;
   logic       busy_q, busy_d;
   logic       tick, restart;
`ifdef PARITY_EN
   logic       par_q, par_d;
`endif

   // timer is held at 0 while idle and reloads at every bit boundary
   assign restart = (state_q == IDLE) || tick;

   bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .restart (restart),
      .tick    (tick)
   );

   // next-state, datapath and registered-output values
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      idx_d     = idx_q;
      ser_out_d = STOP_BIT;
`ifdef PARITY_EN
      par_d     = par_q;
`endif
      case (state_q)
         IDLE: begin
            // ready_q gates acceptance so a load is only taken while ready shows 1
            if (bus.load && ready_q) begin
               shift_d = bus.d_in;
               idx_d   = 3'd0;
`ifdef PARITY_EN
               par_d   = ^bus.d_in;
`endif
               state_d = START;
            end
         end
         START: begin
            ser_out_d = START_BIT;
            if (tick) begin
               idx_d   = 3'd0;
               state_d = DATA;
            end
         end
         DATA: begin
            ser_out_d = shift_q[0];
            if (tick) begin
               shift_d = {1'b0, shift_q[7:1]};
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'(DATA_BITS - 1)) begin
`ifdef PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end
         end
`ifdef PARITY_EN
         PARITY: begin
            ser_out_d = par_q;
            if (tick) state_d = STOP;
         end
`endif
         STOP: begin
            if (tick) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      done_d  = (state_q == STOP) && tick;
      ready_d = (state_q == IDLE);
      busy_d  = !ready_d;
   end

   // state, datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         shift_q   <= 8'd0;
         idx_q     <= 3'd0;
         ser_out_q <= STOP_BIT;
         done_q    <= 1'b0;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         idx_q     <= idx_d;
         ser_out_q <= ser_out_d;
         done_q    <= done_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
      end
   end

`ifdef PARITY_EN
   // parity bit latched with the byte; not disturbed by reset
   always_ff @(posedge clk) begin
      par_q <= par_d;
   end
`endif

   assign bus.ser_out = ser_out_q;
   assign bus.done    = done_q;
   assign bus.ready   = ready_q;
   assign bus.busy    = busy_q;
endmodule
